// File: rtl/sub_seq_pkg.sv
// Shared definitions for the sequential subtractor: default widths,
// slice-count derivation and FSM state encoding.
package sub_seq_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int SLICE_W_DEF = 8;

  // Number of slices for a given operand width and slice width.
  function automatic int calc_nslice(input int width, input int slice_w);
    return width / slice_w;
  endfunction

  // Slice index counter width: clog2 of the slice count, never below one bit.
  function automatic int idx_width(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

  localparam int NSLICE_DEF = calc_nslice(WIDTH_DEF, SLICE_W_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sub_seq_32_slice.sv
// Combinational SLICE_W-bit subtract slice: d = x - y - bi.
// Built as x + ~y + ~bi so the carry-out, inverted, is the borrow-out.
module sub_slice #(
  parameter int SLICE_W = 8
) (
  input  logic [SLICE_W-1:0] x,
  input  logic [SLICE_W-1:0] y,
  input  logic               bi,
  output logic [SLICE_W-1:0] d,
  output logic               bo
);

  logic [SLICE_W:0] sum;

  // One extra bit holds the carry out of the slice.
  always_comb begin
    sum = {1'b0, x} + {1'b0, ~y} + {{SLICE_W{1'b0}}, ~bi};
    d   = sum[SLICE_W-1:0];
    bo  = ~sum[SLICE_W];
  end

endmodule

// File: rtl/sub_seq_32.sv
// Multi-cycle subtractor: diff = a - b - bin, one SLICE_W-bit slice per clock,
// with the borrow rippling through a register. start/busy/done handshake.
// Optional macro SUB_SEQ_FLAGS_EN adds registered zero/neg result flags.
module sub_seq_32
  import sub_seq_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SLICE_W = SLICE_W_DEF
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
`ifdef SUB_SEQ_FLAGS_EN
  ,
  output logic             zero,
  output logic             neg
`endif
);

  localparam int NSLICE = calc_nslice(WIDTH, SLICE_W);
  localparam int IDX_W  = idx_width(NSLICE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic               brw_q;
  logic [WIDTH-1:0]   a_q, b_q, acc_q, acc_next;
  logic [SLICE_W-1:0] slice_x, slice_y, slice_d;
  logic               slice_bo;
  logic               accept, step, last;

  assign accept = (state_q == IDLE) && start;
  assign step   = (state_q == RUN);
  assign last   = step && (idx_q == LAST_IDX);

  // Select the current slice of the registered operands.
  assign slice_x = a_q[idx_q*SLICE_W +: SLICE_W];
  assign slice_y = b_q[idx_q*SLICE_W +: SLICE_W];

  sub_slice #(.SLICE_W(SLICE_W)) u_slice (
    .x  (slice_x),
    .y  (slice_y),
    .bi (brw_q),
    .d  (slice_d),
    .bo (slice_bo)
  );

  // Accumulator with the current slice merged in; feeds both acc and diff.
  always_comb begin
    // NOTE: assign a default first in every combinational block so no path leaves a value unassigned, which would infer a latch.
    acc_next = acc_q;
    acc_next[idx_q*SLICE_W +: SLICE_W] = slice_d;
  end

  // FSM state register.
  always_ff @(posedge clock or negedge clear_n) begin
    // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
    if (!clear_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        busy = 1'b1;
        if (idx_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, per-slice accumulation and result registers.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      // NOTE: these are plain registers, not a memory array, so all of them are reset to a known value, including the operands.
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      idx_q <= '0;
      brw_q <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
`ifdef SUB_SEQ_FLAGS_EN
      zero  <= 1'b0;
      neg   <= 1'b0;
`endif
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      brw_q <= bin;
      idx_q <= '0;
      acc_q <= '0;
    end else if (step) begin
      acc_q <= acc_next;
      brw_q <= slice_bo;
      idx_q <= idx_q + 1'b1;
      if (last) begin
        diff <= acc_next;
        bout <= slice_bo;
        ovf  <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (acc_next[WIDTH-1] ^ a_q[WIDTH-1]);
`ifdef SUB_SEQ_FLAGS_EN
        zero <= (acc_next == '0);
        neg  <= acc_next[WIDTH-1];
`endif
      end
    end
  end

endmodule
